ps2_frame_receiver: RTL and testbench
=====================================

Name: ps2_frame_receiver

Overview:
- Upstream stage of the keyboard path. Converts raw PS/2 clock/data lines from the USB-HID bridge into validated scan-code bytes.
- Presents the last two received bytes as a 16-bit keycode plus a one-cycle valid flag, which feed the make/break filter and the Enigma character path.
- Replaces the unfiltered Digilent receiver. Adds a glitch filter, frame checking, a mid-frame timeout and an error pulse.

Parameters:
- FILTER_LEN, 8: consecutive clk cycles a synchronized PS/2 line must hold a new level before the filtered line changes (range 2..255).
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered kclk falling edge, while mid-frame, before the frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock (CLK50MHZ domain); all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- kclk  input  1  raw PS/2 clock, asynchronous to clk.
- kdata  input  1  raw PS/2 data, asynchronous to clk.
- keycode  output  16  {previous byte, latest byte}.
- oflag  output  1  one-cycle pulse: keycode just updated with a good frame.
- frame_err  output  1  one-cycle pulse: frame dropped (start/stop/parity error or timeout).

Behaviour:
- Reset (async, active-high):
  - keycode=16'h0000, oflag=0, frame_err=0, state=IDLE.
  - Synchronizers, filters and the filtered lines are forced to 1. Bit counter and timeout counter are cleared.
  - Reset mid-frame discards the partial frame, with no pulse.
- Input conditioning:
  - kclk and kdata each pass through a 2-flop synchronizer.
  - Each then passes through a saturating stability counter. The filtered output flips only after FILTER_LEN consecutive cycles at the new level.
  - Falling edge = filtered kclk registered 1 then currently 0. It is a single-cycle strobe.
- Sampling: on the falling-edge strobe cycle, filtered kdata is shifted in LSB-first.
- State machine:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bitcnt=0. On a falling edge with data=1, stay in IDLE and pulse frame_err.
  - DATA: 8 edges shift into the data register (bitcnt 0..7), then go to PARITY.
  - PARITY: one edge captures the parity bit, then go to STOP.
  - STOP: one edge captures the stop bit, then go to CHECK.
  - CHECK (one cycle, no edge needed):
    - Good frame = stop==1 and odd parity over data+parity.
    - Good: keycode <= {keycode[7:0], data}; oflag=1 for this single cycle.
    - Bad: keycode unchanged; frame_err=1 for this cycle.
    - Always returns to IDLE.
- Latency: oflag and the new keycode are visible on the cycle after the stop-bit falling-edge strobe.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments every cycle and clears on each falling edge.
  - Reaching TIMEOUT_CYCLES goes to IDLE with a one-cycle frame_err pulse and no keycode change.
  - The counter is held at 0 in IDLE and CHECK.
- oflag and frame_err are never high in the same cycle.
- Falling edges arriving during CHECK are ignored. This cannot occur at legal PS/2 rates.
- Repeated identical bytes each produce their own oflag. De-duplication belongs downstream.

Optional Feature:
- PS2_PARITY_CHECK_EN:
  - Defined: parity participates in the good-frame test as above.
  - Undefined: the parity bit is sampled but ignored; good frame = stop==1 only. A wrong-parity frame then updates keycode and pulses oflag.

Test Plan:
- Reset asserted mid-DATA (after 4 bits) then released, followed by a clean frame for 0x1C (parity 0, stop 1) -> no pulse during or after reset; then keycode=16'h001C and one oflag pulse.
- Frames 0xF0 then 0x1C, PS/2 period 2000 clk cycles -> keycode=16'h00F0 after the first frame, 16'hF01C after the second; two oflag pulses, each 1 cycle wide, each on the cycle after the stop-bit edge.
- kclk glitch low for FILTER_LEN-1 cycles while IDLE -> no state change, no pulse. Glitch of FILTER_LEN cycles with kdata=1 -> frame_err pulse only.
- Frame 0x1C with parity bit 1 (wrong) -> with PS2_PARITY_CHECK_EN: frame_err pulse, keycode unchanged. Without it: keycode updates, oflag pulse.
- Stop bit driven 0 on frame 0x32 -> frame_err pulse, keycode unchanged, next good frame 0x32 accepted normally.
- Start bit plus 5 bits, then kclk held high for 50000 cycles -> frame_err at cycle TIMEOUT_CYCLES after the last edge, state IDLE, next frame received correctly.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: synchronizes and glitch-filters kclk/kdata, assembles 11-bit frames, and shifts good bytes into a 16-bit keycode.
// Optional parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kclk,
    input  logic        kdata,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        frame_err
);
    // state  | meaning
    // IDLE   | waiting for a start bit
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | waiting for the parity bit
    // STOP   | waiting for the stop bit; frame verdict taken on its edge
    // CHECK  | one cycle presenting oflag or frame_err
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    localparam int        TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // bit 0 carries kclk, bit 1 carries kdata
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      filt_q, filt_d;
    logic [1:0][7:0] fcnt_q, fcnt_d;
    logic            kclk_prev_q;
    logic            fall;
    logic            kdat;

    state_t          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            good_q, good_d;
    logic            err_q, err_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [15:0]     keycode_q, keycode_d;

    logic            parity_good;
    logic            parity_req;
    logic            frame_ok;

    assign raw  = {kdata, kclk};
    assign fall = kclk_prev_q & ~filt_q[0];
    assign kdat = filt_q[1];

    assign parity_good = ^{shift_q, parity_q};
`ifdef PS2_PARITY_CHECK_EN
    assign parity_req = 1'b1;
`else
    assign parity_req = 1'b0;
`endif
    // kdat is the stop bit when this is consulted
    assign frame_ok = kdat & (parity_good | ~parity_req);

    // Filtered line only follows the synchronized line after FILTER_LEN stable cycles
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = 8'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q      <= '0;
            kclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            kclk_prev_q <= filt_q[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            good_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
            keycode_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            good_q    <= good_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            keycode_q <= keycode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        good_d    = good_q;
        err_d     = 1'b0;
        tmo_d     = '0;
        keycode_d = keycode_q;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    if (!kdat) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (fall) begin
                    if (state_q == S_DATA) begin
                        shift_d  = {kdat, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = S_PARITY;
                    end else if (state_q == S_PARITY) begin
                        parity_d = kdat;
                        state_d  = S_STOP;
                    end else begin
                        // Verdict is taken here so keycode is already updated while oflag is high
                        good_d  = frame_ok;
                        state_d = S_CHECK;
                        if (frame_ok) keycode_d = {keycode_q[7:0], shift_q};
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        keycode   = keycode_q;
        oflag     = (state_q == S_CHECK) && good_q;
        frame_err = ((state_q == S_CHECK) && !good_q) || err_q;
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed scenarios plus randomized frames against a byte-level keycode model.
module tb_ps2_frame_receiver;
    localparam int F    = 8;
    localparam int T    = 600;
    localparam int HALF = 50;
    // Cycles from driving a kclk falling edge to a pulse caused by it: 2 sync + F filter + 1 register
    localparam int LAT  = F + 3;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kclk = 1'b1;
    logic        kdata = 1'b1;
    logic [15:0] keycode;
    logic        oflag;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int          ev_kind[$];
    int          ev_cyc[$];
    logic [15:0] ev_key[$];
    logic        prev_of = 1'b0;
    logic        prev_fe = 1'b0;
    logic [15:0] exp_key = 16'h0000;

    ps2_frame_receiver #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(rst), .kclk(kclk), .kdata(kdata),
        .keycode(keycode), .oflag(oflag), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && (oflag === 1'b1 || frame_err === 1'b1)) begin
            ev_kind.push_back((oflag === 1'b1 ? 1 : 0) + (frame_err === 1'b1 ? 2 : 0));
            ev_cyc.push_back(cyc);
            ev_key.push_back(keycode);
            n_checks++;
            if (oflag === 1'b1 && frame_err === 1'b1) begin
                n_fail++;
                $display("FAIL pulse_exclusive: oflag=%b frame_err=%b at cycle %0d, required not both", oflag, frame_err, cyc);
            end
            n_checks++;
            if ((oflag === 1'b1 && prev_of) || (frame_err === 1'b1 && prev_fe)) begin
                n_fail++;
                $display("FAIL pulse_width: pulse held >1 cycle at cycle %0d, required 1-cycle pulses", cyc);
            end
        end
        prev_of = (oflag === 1'b1);
        prev_fe = (frame_err === 1'b1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, output int last_fall);
        last_fall = 0;
        for (int i = 0; i < nbits; i++) begin
            kdata = bits[i];
            idle(HALF);
            kclk = 1'b0;
            last_fall = cyc;
            idle(HALF);
            kclk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp, output int last_fall);
        send_bits({stp, par, b, 1'b0}, 11, last_fall);
        idle(HALF);
    endtask

    task automatic get_event(output bit got, output int kind, output int c, output logic [15:0] k);
        got = 1'b0; kind = 0; c = 0; k = 16'h0;
        if (ev_kind.size() > 0) begin
            got  = 1'b1;
            kind = ev_kind.pop_front();
            c    = ev_cyc.pop_front();
            k    = ev_key.pop_front();
        end
    endtask

    function automatic bit frame_good(input logic [7:0] b, input logic par, input logic stp);
        return stp && (!PAR_EN || (par == ~^b));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_checks++;
        if (keycode !== 16'h0000 || oflag !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: keycode=%h oflag=%b frame_err=%b, required 0000/0/0", keycode, oflag, frame_err);
        end
        rst = 1'b0;
        exp_key = 16'h0000;
        idle(F + 6);
        n_checks++;
        if (ev_kind.size() != 0 || keycode !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_quiet: events=%0d keycode=%h, required 0 events keycode 0000", ev_kind.size(), keycode);
        end
    endtask

    task automatic test_two_frames();
        logic [7:0] bytes [2];
        bit got; int kind, c, lf; logic [15:0] k;
        bytes[0] = 8'hF0;
        bytes[1] = 8'h1C;
        for (int i = 0; i < 2; i++) begin
            send_frame(bytes[i], ~^bytes[i], 1'b1, lf);
            exp_key = {exp_key[7:0], bytes[i]};
            get_event(got, kind, c, k);
            n_checks++;
            if (!got || kind != 1 || c != lf + LAT || k !== exp_key) begin
                n_fail++;
                $display("FAIL two_frames_pulse%0d: got=%0d kind=%0d cycle=%0d key=%h, required oflag at %0d key=%h",
                         i, got, kind, c, k, lf + LAT, exp_key);
            end
            n_checks++;
            if (ev_kind.size() != 0 || keycode !== exp_key) begin
                n_fail++;
                $display("FAIL two_frames_after%0d: extra=%0d keycode=%h, required 0 extra keycode=%h", i, ev_kind.size(), keycode, exp_key);
            end
        end
    endtask

    task automatic test_glitch();
        bit got; int kind, c, d; logic [15:0] k;
        kdata = 1'b1;
        kclk = 1'b0;
        idle(F - 1);
        kclk = 1'b1;
        idle(F + 6);
        n_checks++;
        if (ev_kind.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_short: events=%0d, required 0", ev_kind.size());
        end
        kclk = 1'b0;
        d = cyc;
        idle(F);
        kclk = 1'b1;
        idle(F + 6);
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 2 || c != d + LAT || k !== exp_key || ev_kind.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_long: got=%0d kind=%0d cycle=%0d key=%h, required frame_err at %0d key=%h",
                     got, kind, c, k, d + LAT, exp_key);
        end
        idle(HALF);
    endtask

    task automatic test_bad_parity();
        bit got; int kind, c, lf; logic [15:0] k;
        send_frame(8'h1C, 1'b1, 1'b1, lf);
        if (frame_good(8'h1C, 1'b1, 1'b1)) exp_key = {exp_key[7:0], 8'h1C};
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != (PAR_EN ? 2 : 1) || c != lf + LAT || k !== exp_key || keycode !== exp_key) begin
            n_fail++;
            $display("FAIL bad_parity: got=%0d kind=%0d cycle=%0d key=%h, required kind %0d at %0d key=%h",
                     got, kind, c, keycode, PAR_EN ? 2 : 1, lf + LAT, exp_key);
        end
    endtask

    task automatic test_bad_stop();
        bit got; int kind, c, lf; logic [15:0] k;
        send_frame(8'h32, 1'b0, 1'b0, lf);
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 2 || c != lf + LAT || keycode !== exp_key) begin
            n_fail++;
            $display("FAIL bad_stop: got=%0d kind=%0d cycle=%0d key=%h, required frame_err at %0d key=%h",
                     got, kind, c, keycode, lf + LAT, exp_key);
        end
        send_frame(8'h32, 1'b0, 1'b1, lf);
        exp_key = {exp_key[7:0], 8'h32};
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 1 || c != lf + LAT || k !== exp_key) begin
            n_fail++;
            $display("FAIL stop_recover: got=%0d kind=%0d cycle=%0d key=%h, required oflag at %0d key=%h",
                     got, kind, c, k, lf + LAT, exp_key);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit got; int kind, c, lf; logic [15:0] k;
        logic [7:0] b;
        b = 8'h1C;
        send_bits({6'b0, b[3:0], 1'b0}, 5, lf);
        idle(2);
        rst = 1'b1;
        idle(4);
        n_checks++;
        if (keycode !== 16'h0000 || oflag !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_values: keycode=%h oflag=%b frame_err=%b, required 0000/0/0", keycode, oflag, frame_err);
        end
        rst = 1'b0;
        exp_key = 16'h0000;
        idle(F + 6);
        n_checks++;
        if (ev_kind.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: events=%0d, required 0", ev_kind.size());
        end
        send_frame(b, 1'b0, 1'b1, lf);
        exp_key = 16'h001C;
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 1 || c != lf + LAT || k !== 16'h001C || ev_kind.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got=%0d kind=%0d cycle=%0d key=%h, required oflag at %0d key=001c",
                     got, kind, c, k, lf + LAT);
        end
    endtask

    task automatic test_timeout();
        bit got; int kind, c, lf, strobe, waited; logic [15:0] k;
        logic [7:0] b;
        send_bits({6'b0, 5'b10110, 1'b0}, 6, lf);
        strobe = lf + LAT - 1;
        waited = 0;
        while (ev_kind.size() == 0 && waited < T + 200) begin
            idle(1);
            waited++;
        end
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 2 || c < strobe + T || c > strobe + T + 2 || k !== exp_key) begin
            n_fail++;
            $display("FAIL timeout: got=%0d kind=%0d cycle=%0d key=%h, required frame_err in [%0d,%0d] key=%h",
                     got, kind, c, k, strobe + T, strobe + T + 2, exp_key);
        end
        idle(HALF);
        b = 8'(($urandom));
        send_frame(b, ~^b, 1'b1, lf);
        exp_key = {exp_key[7:0], b};
        get_event(got, kind, c, k);
        n_checks++;
        if (!got || kind != 1 || c != lf + LAT || k !== exp_key) begin
            n_fail++;
            $display("FAIL timeout_recover: got=%0d kind=%0d cycle=%0d key=%h, required oflag at %0d key=%h",
                     got, kind, c, k, lf + LAT, exp_key);
        end
    endtask

    task automatic test_random();
        bit got; int kind, c, lf, sel; logic [15:0] k;
        logic [7:0] b; logic par, stp; bit good;
        for (int i = 0; i < 24; i++) begin
            b   = 8'($urandom);
            sel = $urandom_range(0, 3);
            par = (sel == 2) ? ^b : ~^b;
            stp = (sel != 3);
            good = frame_good(b, par, stp);
            send_frame(b, par, stp, lf);
            if (good) exp_key = {exp_key[7:0], b};
            get_event(got, kind, c, k);
            n_checks++;
            if (!got || kind != (good ? 1 : 2) || c != lf + LAT || k !== exp_key || ev_kind.size() != 0) begin
                n_fail++;
                $display("FAIL random%0d byte=%h par=%b stop=%b: got=%0d kind=%0d cycle=%0d key=%h, required kind %0d at %0d key=%h",
                         i, b, par, stp, got, kind, c, k, good ? 1 : 2, lf + LAT, exp_key);
            end
            idle($urandom_range(0, 40));
        end
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_glitch();
        test_bad_parity();
        test_bad_stop();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        idle(20);
        n_checks++;
        if (ev_kind.size() != 0) begin
            n_fail++;
            $display("FAIL trailing_events: events=%0d, required 0", ev_kind.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
